// File: rtl/io_pkg.sv
// io_pkg: shared helpers for the IO write dispatcher.
//   clog2       - ceiling log2, used for FIFO pointer/level widths
//   block_mask  - address mask that strips the in-block offset bits
//   entry_w     - width of one posted-write entry {offset, data}
package io_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Ones above the offset field, zeros in it; callers truncate to their bus width.
    function automatic logic [63:0] block_mask(input int block_size);
        return ~((64'd1 << block_size) - 64'd1);
    endfunction

    function automatic int entry_w(input int block_size, input int data_width);
        return block_size + data_width;
    endfunction

endpackage

// File: rtl/io_wr_fifo.sv
// io_wr_fifo: synchronous posted-write FIFO, first-word-fall-through head.
//   clk, rst_n  clock / async active-low reset
//   i_push      write i_din (ignored when full)
//   i_pop       drop head entry (ignored when empty)
//   o_dout      current head entry (valid when !o_empty)
//   o_full      level == DEPTH
//   o_empty     level == 0
//   o_level     occupancy 0..DEPTH
module io_wr_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [clog2(DEPTH):0]  o_level
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage needs no reset: level/pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/io_write_dispatch.sv
// io_write_dispatch: decodes CPU IO writes into one address block, posts them
// into a small FIFO and replays each as a one-cycle write enable on its channel.
//   clk, rst_n    clock / async active-low reset
//   cpu_din       CPU write data
//   cpu_addr      CPU address; low BLOCK_SIZE bits select the channel
//   io_wr         CPU write strobe, one write per high cycle
//   io_stall      write hits the block while the FIFO is full
//   ch_ready      per-channel accept
//   io_dout       registered dispatched data (holds between writes)
//   io_we         registered one-hot write enable
//   fifo_level    FIFO occupancy
//   err_clr       clear both sticky flags
//   err_overflow  sticky: block write dropped on full FIFO
//   err_unmapped  sticky: block write to offset >= NUM_CH
module io_write_dispatch
    import io_pkg::*;
#(
    parameter int                   DATA_WIDTH    = 16,
    parameter int                   ADDRESS_WIDTH = 16,
    parameter int                   BLOCK_SIZE    = 5,
    parameter logic [ADDRESS_WIDTH-1:0] IO_BASE_ADDR = 16'h1000,
    parameter int                   NUM_CH        = 4,
    parameter int                   FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       cpu_din,
    input  logic [ADDRESS_WIDTH-1:0]    cpu_addr,
    input  logic                        io_wr,
    output logic                        io_stall,
    input  logic [NUM_CH-1:0]           ch_ready,
    output logic [DATA_WIDTH-1:0]       io_dout,
    output logic [NUM_CH-1:0]           io_we,
    output logic [clog2(FIFO_DEPTH):0]  fifo_level,
    input  logic                        err_clr,
    output logic                        err_overflow,
    output logic                        err_unmapped
);

    localparam int EW = entry_w(BLOCK_SIZE, DATA_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] IO_BASE_MASK = ADDRESS_WIDTH'(block_mask(BLOCK_SIZE));
    localparam logic [BLOCK_SIZE:0]      NUM_CH_W     = (BLOCK_SIZE + 1)'(NUM_CH);

    logic                  w_hit;
    logic [BLOCK_SIZE-1:0] w_off;
    logic                  w_mapped;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [EW-1:0]         w_head;
    logic [BLOCK_SIZE-1:0] w_head_off;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [NUM_CH-1:0]     w_head_oh;

    assign w_hit    = io_wr & ((cpu_addr & IO_BASE_MASK) == IO_BASE_ADDR);
    assign w_off    = cpu_addr[BLOCK_SIZE-1:0];
    assign w_mapped = ({1'b0, w_off} < NUM_CH_W);
    // Full blocks the push even if the head pops this cycle (no write-through).
    assign w_push   = w_hit & w_mapped & ~w_full;
    assign io_stall = w_hit & w_full;

    io_wr_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ({w_off, cpu_din}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign w_head_off  = w_head[EW-1:DATA_WIDTH];
    assign w_head_data = w_head[DATA_WIDTH-1:0];

    // Stored offsets are always < NUM_CH, so this is exactly one-hot.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_oh
        assign w_head_oh[i] = (w_head_off == BLOCK_SIZE'(i));
    end

    // Strictly in-order: only the head's own channel ready can release it.
    assign w_pop = ~w_empty & |(w_head_oh & ch_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_we   <= '0;
            io_dout <= '0;
        end else begin
            io_we <= w_pop ? w_head_oh : '0;
            if (w_pop) io_dout <= w_head_data;
        end
    end

    // Set has priority over clear so a same-cycle event is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
            err_unmapped <= 1'b0;
        end else begin
            if (w_hit & w_full)         err_overflow <= 1'b1;
            else if (err_clr)           err_overflow <= 1'b0;
            if (w_hit & ~w_mapped)      err_unmapped <= 1'b1;
            else if (err_clr)           err_unmapped <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_write_dispatch.sv
module tb_io_write_dispatch;

    typedef struct packed {
        logic [3:0]  we;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_din;
    logic [15:0] cpu_addr;
    logic        io_wr;
    logic        io_stall;
    logic [3:0]  ch_ready;
    logic [15:0] io_dout;
    logic [3:0]  io_we;
    logic [2:0]  fifo_level;
    logic        err_clr;
    logic        err_overflow;
    logic        err_unmapped;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    io_write_dispatch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_din      (cpu_din),
        .cpu_addr     (cpu_addr),
        .io_wr        (io_wr),
        .io_stall     (io_stall),
        .ch_ready     (ch_ready),
        .io_dout      (io_dout),
        .io_we        (io_we),
        .fifo_level   (fifo_level),
        .err_clr      (err_clr),
        .err_overflow (err_overflow),
        .err_unmapped (err_unmapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [15:0] a, input logic [15:0] d);
        io_wr    = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
    endtask

    task automatic idle();
        io_wr = 1'b0;
    endtask

    // Scoreboard monitor: every enable pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && io_we != 4'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: io_we=%b io_dout=%h with nothing expected at %0t",
                         io_we, io_dout, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_we", {28'd0, io_we}, {28'd0, e.we});
                chk("sb_dout", {16'd0, io_dout}, {16'd0, e.d});
            end
        end
    end

    initial begin
        rst_n = 1'b0; io_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
        ch_ready = 4'h0; err_clr = 1'b0;

        // Reset values before any clock edge
        #2;
        chk("rst_we", {28'd0, io_we}, 0);
        chk("rst_dout", {16'd0, io_dout}, 0);
        chk("rst_level", {29'd0, fifo_level}, 0);
        chk("rst_stall", {31'd0, io_stall}, 0);
        chk("rst_flags", {30'd0, err_overflow, err_unmapped}, 0);
        @(negedge clk); rst_n = 1'b1;

        // Single write, 2-clock latency, one-cycle pulse
        cyc(); ch_ready = 4'hF; drv(16'h1002, 16'hBEEF);
        exp_q.push_back('{we: 4'b0100, d: 16'hBEEF});
        @(negedge clk); chk("t2_stall", {31'd0, io_stall}, 0);
        cyc(); idle();
        @(negedge clk); chk("t2_we_e1", {28'd0, io_we}, 0);
        chk("t2_level_e1", {29'd0, fifo_level}, 1);
        cyc();
        @(negedge clk); chk("t2_we_e2", {28'd0, io_we}, 4'b0100);
        chk("t2_dout_e2", {16'd0, io_dout}, 16'hBEEF);
        chk("t2_level_e2", {29'd0, fifo_level}, 0);
        cyc();
        @(negedge clk); chk("t2_we_e3", {28'd0, io_we}, 0);
        chk("t2_dout_hold", {16'd0, io_dout}, 16'hBEEF);

        // Fill with nothing ready: 5th write stalls and is dropped
        cyc(); ch_ready = 4'h0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            drv(16'h1000, 16'h3000 + 16'(k));
            if (k < 4) exp_q.push_back('{we: 4'b0001, d: 16'h3000 + 16'(k)});
            @(negedge clk); chk("t3_stall", {31'd0, io_stall}, (k == 4) ? 1 : 0);
        end
        cyc(); idle();
        @(negedge clk); chk("t3_level", {29'd0, fifo_level}, 4);
        chk("t3_ovf", {31'd0, err_overflow}, 1);
        chk("t3_unm", {31'd0, err_unmapped}, 0);
        cyc(); ch_ready = 4'hF;
        repeat (6) cyc();
        @(negedge clk); chk("t3_drained", {29'd0, fifo_level}, 0);
        chk("t3_sb_empty", exp_q.size(), 0);
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0;
        @(negedge clk); chk("t3_ovf_clr", {31'd0, err_overflow}, 0);

        // Unmapped offset, out-of-block address, clear vs set priority
        cyc(); drv(16'h1007, 16'h1234);
        @(negedge clk); chk("t4_stall", {31'd0, io_stall}, 0);
        cyc(); drv(16'h2002, 16'h5555);
        @(negedge clk); chk("t4_level_a", {29'd0, fifo_level}, 0);
        chk("t4_unm", {31'd0, err_unmapped}, 1);
        cyc(); idle();
        @(negedge clk); chk("t4_level_b", {29'd0, fifo_level}, 0);
        cyc(); err_clr = 1'b1; drv(16'h1005, 16'h7777);
        cyc(); err_clr = 1'b0; idle();
        @(negedge clk); chk("t4_set_wins", {31'd0, err_unmapped}, 1);
        cyc(); err_clr = 1'b1;
        cyc(); err_clr = 1'b0;
        @(negedge clk); chk("t4_unm_clr", {31'd0, err_unmapped}, 0);

        // Head-of-line blocking
        cyc(); ch_ready = 4'b0001; drv(16'h1001, 16'hA1A1);
        exp_q.push_back('{we: 4'b0010, d: 16'hA1A1});
        cyc(); drv(16'h1000, 16'hA0A0);
        exp_q.push_back('{we: 4'b0001, d: 16'hA0A0});
        cyc(); idle();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); chk("t5_blocked", {28'd0, io_we}, 0);
            cyc();
        end
        ch_ready = 4'b0011;
        @(negedge clk); chk("t5_level", {29'd0, fifo_level}, 2);
        cyc();
        @(negedge clk); chk("t5_we_ch1", {28'd0, io_we}, 4'b0010);
        chk("t5_dout_ch1", {16'd0, io_dout}, 16'hA1A1);
        cyc();
        @(negedge clk); chk("t5_we_ch0", {28'd0, io_we}, 4'b0001);
        chk("t5_dout_ch0", {16'd0, io_dout}, 16'hA0A0);
        cyc();
        @(negedge clk); chk("t5_we_done", {28'd0, io_we}, 0);

        // Back-to-back stream with all channels ready
        cyc(); ch_ready = 4'hF;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) cyc();
            drv(16'h1000 + 16'(j % 4), 16'h6000 + 16'(j));
            exp_q.push_back('{we: 4'(1 << (j % 4)), d: 16'h6000 + 16'(j)});
            @(negedge clk);
            chk("t6_stall", {31'd0, io_stall}, 0);
            chk("t6_level_le1", {31'd0, (fifo_level <= 3'd1)}, 1);
            if (j >= 2) chk("t6_pulse", {31'd0, (io_we != 4'b0)}, 1);
        end
        cyc(); idle();
        repeat (3) cyc();
        @(negedge clk); chk("t6_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a burst, while a pulse is being driven
        cyc(); ch_ready = 4'h0; drv(16'h1000, 16'hC000);
        exp_q.push_back('{we: 4'b0001, d: 16'hC000});
        cyc(); drv(16'h1001, 16'hC001);
        exp_q.push_back('{we: 4'b0010, d: 16'hC001});
        cyc(); drv(16'h1009, 16'hC009);
        cyc(); idle(); ch_ready = 4'hF;
        @(posedge clk); #2;
        chk("t1_pre_we", {28'd0, io_we}, 4'b0001);
        chk("t1_pre_unm", {31'd0, err_unmapped}, 1);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("t1_we", {28'd0, io_we}, 0);
        chk("t1_level", {29'd0, fifo_level}, 0);
        chk("t1_dout", {16'd0, io_dout}, 0);
        chk("t1_flags", {30'd0, err_overflow, err_unmapped}, 0);
        chk("t1_stall", {31'd0, io_stall}, 0);
        repeat (2) cyc();
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            cyc();
            @(negedge clk); chk("t1_post_we", {28'd0, io_we}, 0);
        end
        chk("t1_post_level", {29'd0, fifo_level}, 0);

        chk("final_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
